mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-outstanding memory port between an instruction-fetch
//   requester and a data (load/store) requester. The data port has priority
//   because its access belongs to the older instruction in the pipeline.
//   Each access is bounded by a wait counter. If the counter expires, the
//   access completes with an error flag.
//
// Ports
//   clk, reset              : clock; asynchronous active-high reset
//   IReq, IAddr             : fetch request and fetch address
//   IDone, IRData, IErr     : fetch completion pulse, fetched word, timeout flag
//   DReq, DWe, DAddr, DWData: data request, write enable, address, write data
//   DDone, DRData, DErr     : data completion pulse, load data, timeout flag
//   MemReq, MemWe,
//   MemAddr, MemWData       : memory-side request (stable while busy)
//   MemAck, MemRData        : memory completion and read data
//   Busy                    : high whenever an access is in flight
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic        IDone,
  output logic [31:0] IRData,
  output logic        IErr,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  output logic        DDone,
  output logic [31:0] DRData,
  output logic        DErr,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        Busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IBUSY = 2'd1;
  localparam logic [1:0] S_DBUSY = 2'd2;

  // The counter starts at 0 in the first busy cycle. The access times out
  // on the edge that ends busy cycle number MAX_WAIT.
  localparam logic [7:0] TIMEOUT_CNT = 8'(MAX_WAIT - 32'd1);

  logic [1:0]  r_state;
  logic        r_busy;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [7:0]  r_wait_cnt;
  logic        r_idone;
  logic        r_ddone;
  logic        r_ierr;
  logic        r_derr;
  logic [31:0] r_irdata;
  logic [31:0] r_drdata;

  logic w_ireq_ok;
  logic w_dreq_ok;
  logic w_timeout;

  // A port whose Done is showing is not eligible this edge. This stops a
  // held request from re-issuing and lets the other port go next.
  assign w_ireq_ok = IReq & ~r_idone;
  assign w_dreq_ok = DReq & ~r_ddone;
  assign w_timeout = (r_wait_cnt == TIMEOUT_CNT);

  // Arbitration FSM, memory-side request registers and completion outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_wait_cnt  <= 8'd0;
      r_idone     <= 1'b0;
      r_ddone     <= 1'b0;
      r_ierr      <= 1'b0;
      r_derr      <= 1'b0;
      r_irdata    <= 32'd0;
      r_drdata    <= 32'd0;
    end else begin
      // Done is a single-cycle pulse unless a completion re-asserts it below.
      r_idone <= 1'b0;
      r_ddone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_dreq_ok) begin
            r_state     <= S_DBUSY;
            r_busy      <= 1'b1;
            r_mem_we    <= DWe;
            r_mem_addr  <= DAddr;
            r_mem_wdata <= DWData;
            r_wait_cnt  <= 8'd0;
          end else if (w_ireq_ok) begin
            r_state    <= S_IBUSY;
            r_busy     <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= IAddr;
            r_wait_cnt <= 8'd0;
          end else begin
            // MemAck is ignored while idle.
            r_state <= S_IDLE;
          end
        end
        S_IBUSY: begin
          // Ack wins over a timeout on the same edge.
          if (MemAck) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_idone  <= 1'b1;
            r_ierr   <= 1'b0;
            r_irdata <= MemRData;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_idone <= 1'b1;
            r_ierr  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_DBUSY: begin
          if (MemAck) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ddone <= 1'b1;
            r_derr  <= 1'b0;
            // Stores leave the load-data register untouched.
            if (!r_mem_we) begin
              r_drdata <= MemRData;
            end else begin
              r_drdata <= r_drdata;
            end
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ddone <= 1'b1;
            r_derr  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign MemReq   = r_busy;
  assign Busy     = r_busy;
  assign MemWe    = r_mem_we;
  assign MemAddr  = r_mem_addr;
  assign MemWData = r_mem_wdata;
  assign IDone    = r_idone;
  assign IErr     = r_ierr;
  assign IRData   = r_irdata;
  assign DDone    = r_ddone;
  assign DErr     = r_derr;
  assign DRData   = r_drdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed testbench for mem_port_arbiter, built with MAX_WAIT=4. Inputs
//   are driven 1 ns after a rising edge, and outputs are sampled at the same
//   point.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IDone;
  logic [31:0] IRData;
  logic        IErr;
  logic        DReq;
  logic        DWe;
  logic [31:0] DAddr;
  logic [31:0] DWData;
  logic        DDone;
  logic [31:0] DRData;
  logic        DErr;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        MemAck;
  logic [31:0] MemRData;
  logic        Busy;

  int checks;
  int errors;

  mem_port_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .IReq(IReq), .IAddr(IAddr), .IDone(IDone), .IRData(IRData), .IErr(IErr),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
    .DDone(DDone), .DRData(DRData), .DErr(DErr),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemAck(MemAck), .MemRData(MemRData), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    IReq = 1'b0; IAddr = 32'd0;
    DReq = 1'b0; DWe = 1'b0; DAddr = 32'd0; DWData = 32'd0;
    MemAck = 1'b0; MemRData = 32'd0;
    tick();
    tick();
    checks++;
    if ({MemReq, MemWe, IDone, DDone, IErr, DErr, Busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000", {MemReq, MemWe, IDone, DDone, IErr, DErr, Busy});
    end
    checks++;
    if ({MemAddr, MemWData, IRData, DRData} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h expected all 0", MemAddr, MemWData, IRData, DRData);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_ack();
    MemAck = 1'b1; MemRData = 32'h1234_5678;
    tick();
    checks++;
    if ({IDone, DDone, Busy, MemReq} !== 4'b0 || DRData !== 32'd0 || IRData !== 32'd0) begin
      errors++;
      $display("FAIL idle_ack: got done=%b%b busy=%b drd=%h ird=%h expected quiet", IDone, DDone, Busy, DRData, IRData);
    end
    MemAck = 1'b0;
  endtask

  task automatic test_priority();
    IReq = 1'b1; IAddr = 32'h0000_0100;
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h0000_2000;
    tick();
    checks++;
    if (MemReq !== 1'b1 || Busy !== 1'b1 || MemAddr !== 32'h0000_2000 || MemWe !== 1'b0) begin
      errors++;
      $display("FAIL prio_data_first: got req=%b addr=%h we=%b expected 1 00002000 0", MemReq, MemAddr, MemWe);
    end
    MemAck = 1'b1; MemRData = 32'hA5A5_0001;
    tick();
    checks++;
    if (DDone !== 1'b1 || DErr !== 1'b0 || DRData !== 32'hA5A5_0001 || MemReq !== 1'b0 || IDone !== 1'b0) begin
      errors++;
      $display("FAIL prio_ddone: got ddone=%b derr=%b drd=%h req=%b expected 1 0 a5a50001 0", DDone, DErr, DRData, MemReq);
    end
    // DReq still held: masked during DDone, so the fetch goes next.
    MemAck = 1'b0;
    tick();
    DReq = 1'b0;
    checks++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h0000_0100 || MemWe !== 1'b0 || DDone !== 1'b0) begin
      errors++;
      $display("FAIL prio_fetch_next: got req=%b addr=%h ddone=%b expected 1 00000100 0", MemReq, MemAddr, DDone);
    end
    MemAck = 1'b1; MemRData = 32'h1111_2222;
    tick();
    checks++;
    if (IDone !== 1'b1 || IErr !== 1'b0 || IRData !== 32'h1111_2222 || DRData !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL prio_idone: got idone=%b ierr=%b ird=%h drd=%h expected 1 0 11112222 a5a50001", IDone, IErr, IRData, DRData);
    end
    IReq = 1'b0; MemAck = 1'b0;
    tick();
    checks++;
    if (IDone !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_pulse_end: got idone=%b busy=%b expected 0 0", IDone, Busy);
    end
  endtask

  task automatic test_write();
    DReq = 1'b1; DWe = 1'b1; DAddr = 32'h0000_0040; DWData = 32'hDEAD_BEEF;
    tick();
    // Scramble requester inputs; memory-side registers must not follow.
    DAddr = 32'hFFFF_FFFF; DWData = 32'h0BAD_0BAD; DWe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (MemReq !== 1'b1 || MemWe !== 1'b1 || MemWData !== 32'hDEAD_BEEF || MemAddr !== 32'h0000_0040) begin
        errors++;
        $display("FAIL write_busy%0d: got req=%b we=%b wd=%h addr=%h expected 1 1 deadbeef 00000040", i, MemReq, MemWe, MemWData, MemAddr);
      end
      if (i == 2) begin
        MemAck = 1'b1; MemRData = 32'h5555_5555;
      end
      tick();
    end
    checks++;
    if (DDone !== 1'b1 || DErr !== 1'b0 || DRData !== 32'hA5A5_0001 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL write_done: got ddone=%b derr=%b drd=%h busy=%b expected 1 0 a5a50001 0", DDone, DErr, DRData, Busy);
    end
    DReq = 1'b0; MemAck = 1'b0;
    tick();
    checks++;
    if (DDone !== 1'b0 || DRData !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL write_pulse_end: got ddone=%b drd=%h expected 0 a5a50001", DDone, DRData);
    end
  endtask

  task automatic test_timeout();
    int cycles;
    IReq = 1'b1; IAddr = 32'h0000_0300; MemAck = 1'b0;
    tick();
    cycles = 0;
    while (MemReq === 1'b1 && cycles < 20) begin
      cycles++;
      tick();
    end
    checks++;
    if (cycles !== 4) begin
      errors++;
      $display("FAIL timeout_len: got %0d busy cycles expected 4", cycles);
    end
    checks++;
    if (IDone !== 1'b1 || IErr !== 1'b1 || IRData !== 32'h1111_2222 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_done: got idone=%b ierr=%b ird=%h busy=%b expected 1 1 11112222 0", IDone, IErr, IRData, Busy);
    end
    IReq = 1'b0;
    tick();
    checks++;
    if (IDone !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse_end: got idone=%b busy=%b expected 0 0", IDone, Busy);
    end
  endtask

  task automatic test_ack_on_timeout();
    IReq = 1'b1; IAddr = 32'h0000_0400;
    tick();
    tick();
    tick();
    tick();
    // The next edge is the timeout edge; an ack there must complete normally.
    MemAck = 1'b1; MemRData = 32'hCAFE_F00D;
    tick();
    checks++;
    if (IDone !== 1'b1 || IErr !== 1'b0 || IRData !== 32'hCAFE_F00D || Busy !== 1'b0) begin
      errors++;
      $display("FAIL ack_on_timeout: got idone=%b ierr=%b ird=%h busy=%b expected 1 0 cafef00d 0", IDone, IErr, IRData, Busy);
    end
    IReq = 1'b0; MemAck = 1'b0;
    tick();
  endtask

  task automatic test_held_req();
    IReq = 1'b1; IAddr = 32'h0000_0500;
    tick();
    MemAck = 1'b1; MemRData = 32'h0000_0500;
    tick();
    checks++;
    if (IDone !== 1'b1 || IRData !== 32'h0000_0500) begin
      errors++;
      $display("FAIL held_done: got idone=%b ird=%h expected 1 00000500", IDone, IRData);
    end
    MemAck = 1'b0;
    tick();
    checks++;
    if (MemReq !== 1'b0 || Busy !== 1'b0 || IDone !== 1'b0) begin
      errors++;
      $display("FAIL held_no_dup: got req=%b busy=%b idone=%b expected 0 0 0", MemReq, Busy, IDone);
    end
    IReq = 1'b0;
    tick();
  endtask

  task automatic test_mid_deassert();
    IReq = 1'b1; IAddr = 32'h0000_0600;
    tick();
    IReq = 1'b0;
    tick();
    checks++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h0000_0600) begin
      errors++;
      $display("FAIL deassert_keeps: got req=%b addr=%h expected 1 00000600", MemReq, MemAddr);
    end
    MemAck = 1'b1; MemRData = 32'h0600_0600;
    tick();
    checks++;
    if (IDone !== 1'b1 || IRData !== 32'h0600_0600) begin
      errors++;
      $display("FAIL deassert_done: got idone=%b ird=%h expected 1 06000600", IDone, IRData);
    end
    MemAck = 1'b0;
    tick();
  endtask

  task automatic test_abort_reset();
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h0000_0700;
    tick();
    checks++;
    if (MemReq !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: got req=%b expected 1", MemReq);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({MemReq, MemWe, IDone, DDone, IErr, DErr, Busy} !== 7'b0) begin
      errors++;
      $display("FAIL abort_async: got %b expected 0000000", {MemReq, MemWe, IDone, DDone, IErr, DErr, Busy});
    end
    checks++;
    if ({MemAddr, MemWData, IRData, DRData} !== 128'd0) begin
      errors++;
      $display("FAIL abort_data: got %h %h %h %h expected all 0", MemAddr, MemWData, IRData, DRData);
    end
    MemAck = 1'b1; MemRData = 32'h7777_7777;
    tick();
    DReq = 1'b0; MemAck = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (DDone !== 1'b0 || DRData !== 32'd0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got ddone=%b drd=%h busy=%b expected 0 0 0", DDone, DRData, Busy);
    end
  endtask

  task automatic test_release_accept();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h0000_0800;
    tick();
    checks++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h0000_0800) begin
      errors++;
      $display("FAIL release_accept: got req=%b addr=%h expected 1 00000800", MemReq, MemAddr);
    end
    MemAck = 1'b1; MemRData = 32'h8888_0800;
    tick();
    checks++;
    if (DDone !== 1'b1 || DRData !== 32'h8888_0800) begin
      errors++;
      $display("FAIL release_done: got ddone=%b drd=%h expected 1 88880800", DDone, DRData);
    end
    DReq = 1'b0; MemAck = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_idle_ack();
    test_priority();
    test_write();
    test_timeout();
    test_ack_on_timeout();
    test_held_req();
    test_mid_deassert();
    test_abort_reset();
    test_release_accept();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
